// File: rtl/imem_loader.sv
// Byte-stream program loader: packs incoming bytes into 32-bit words and emits one-cycle imem writes.
// Optional macro IMEM_LOADER_BIG_ENDIAN_EN selects big-endian byte packing (default little-endian).
module imem_loader #(
  parameter int PC_SIZE       = 32,
  parameter int INSTR_SIZE    = 32,
  parameter int MAX_IMEM_ROWS = 4096,
  localparam int CW           = $clog2(MAX_IMEM_ROWS) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_i,
  input  logic                  last_i,
  output logic                  byte_ready_o,
  output logic                  wr_en_o,
  output logic [PC_SIZE-1:0]    wr_addr_o,
  output logic [INSTR_SIZE-1:0] wr_data_o,
  output logic [CW-1:0]         num_instr_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [1:0]            dbg_state
);

  // Handshake: a byte transfers on any rising edge where byte_valid_i && byte_ready_o;
  // byte_ready_o is high for the whole LOAD state and low everywhere else.

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_t;

  state_t      state;
  logic [1:0]  byte_cnt;
  logic [23:0] partial;
  logic [31:0] word;
  logic        accept;
  logic        last_word;

  assign dbg_state = state;
  assign accept    = byte_valid_i && byte_ready_o;
  assign last_word = (num_instr_o == CW'(MAX_IMEM_ROWS - 1));

  // The current byte is always the fourth byte of the word when a write is issued.
  always_comb begin
    word = '0;
`ifdef IMEM_LOADER_BIG_ENDIAN_EN
    word = {partial[7:0], partial[15:8], partial[23:16], byte_i};
`else
    word = {byte_i, partial[23:16], partial[15:8], partial[7:0]};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      byte_ready_o <= 1'b0;
      wr_en_o      <= 1'b0;
      wr_addr_o    <= '0;
      wr_data_o    <= '0;
      num_instr_o  <= '0;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
      byte_cnt     <= 2'd0;
      partial      <= '0;
    end else begin
      wr_en_o <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start_i) begin
            state        <= LOAD;
            byte_ready_o <= 1'b1;
            byte_cnt     <= 2'd0;
            num_instr_o  <= '0;
            done_o       <= 1'b0;
            error_o      <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            if (last_i && byte_cnt != 2'd3) begin
              // Program ended mid-word: the partial word is discarded.
              state        <= ERROR;
              error_o      <= 1'b1;
              byte_ready_o <= 1'b0;
              byte_cnt     <= 2'd0;
            end else if (byte_cnt == 2'd3) begin
              byte_cnt    <= 2'd0;
              wr_en_o     <= 1'b1;
              wr_data_o   <= INSTR_SIZE'(word);
              wr_addr_o   <= PC_SIZE'({num_instr_o, 2'b00});
              num_instr_o <= num_instr_o + 1'b1;
              if (last_i) begin
                state        <= DONE;
                done_o       <= 1'b1;
                byte_ready_o <= 1'b0;
              end else if (last_word) begin
                state        <= ERROR;
                error_o      <= 1'b1;
                byte_ready_o <= 1'b0;
              end
            end else begin
              partial[{byte_cnt, 3'b000} +: 8] <= byte_i;
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        default: begin
          state        <= IDLE;
          byte_ready_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter PC_SIZE, default 32, address width.
REQ-002 SHALL have parameter INSTR_SIZE, default 32, instruction word width (fixed 4 bytes).
REQ-003 SHALL have parameter MAX_IMEM_ROWS, default 4096, instruction memory capacity in words.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start_i  input  1  begin a new program load.
REQ-007 SHALL have port byte_valid_i  input  1  byte_i holds a valid program byte.
REQ-008 SHALL have port byte_i  input  8  program byte stream.
REQ-009 SHALL have port last_i  input  1  qualifies the final byte of the program.
REQ-010 SHALL have port byte_ready_o  output  1  loader accepts a byte this cycle.
REQ-011 SHALL have port wr_en_o  output  1  one-cycle instruction memory write strobe.
REQ-012 SHALL have port wr_addr_o  output  PC_SIZE  byte address of written word (multiple of 4).
REQ-013 SHALL have port wr_data_o  output  INSTR_SIZE  assembled instruction word.
REQ-014 SHALL have port num_instr_o  output  $clog2(MAX_IMEM_ROWS)+1  words written in current load.
REQ-015 SHALL have port done_o  output  1  load completed cleanly (sticky).
REQ-016 SHALL have port error_o  output  1  load aborted: partial word or overflow (sticky).

Function
REQ-017 SHALL implement states IDLE, LOAD, DONE, ERROR.
REQ-018 IDLE/DONE/ERROR: byte_ready_o=0; start_i=1 -> LOAD next cycle, clearing byte counter, word count, done_o, error_o.
REQ-019 LOAD: byte_ready_o=1; start_i ignored.
REQ-020 Byte accepted only when byte_valid_i && byte_ready_o; 2-bit byte counter increments per accepted byte, wraps 3->0.
REQ-021 Byte k of a word (k=0..3) SHALL occupy bits 8k+7:8k of wr_data_o (little-endian) by default.
REQ-022 Fourth byte accepted in cycle N -> wr_en_o=1 in cycle N+1 only, wr_data_o = full word, wr_addr_o = 4*num_instr_o (pre-increment value); num_instr_o increments in cycle N+1.
REQ-023 wr_data_o and wr_addr_o SHALL hold their last values when wr_en_o=0.
REQ-024 last_i with 4th byte of a word -> write per REQ-022, then state DONE, done_o=1 in cycle N+1.
REQ-025 last_i with byte counter != 3 -> no write, state ERROR, error_o=1 next cycle; partial word discarded.
REQ-026 4th byte completing word MAX_IMEM_ROWS without last_i -> write performed, then state ERROR (overflow), error_o=1 in cycle N+1.
REQ-027 last_i without byte_valid_i SHALL be ignored.
REQ-028 done_o and error_o SHALL never both be 1.
REQ-029 Throughput: one byte per cycle sustained; byte_ready_o SHALL not deassert within LOAD.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE, byte_ready_o=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0, num_instr_o=0, done_o=0, error_o=0, byte counter=0.
REQ-031 rst SHALL override start_i and any in-flight byte or pending write in the same cycle; a pending write is dropped.

Configuration
REQ-032 Macro IMEM_LOADER_BIG_ENDIAN_EN defined: byte k SHALL occupy bits 31-8k:24-8k (big-endian); undefined: little-endian per REQ-021; all other behaviour identical.

Verification
REQ-033 Reset, start_i, bytes 13,05,A0,00 with last_i on 4th -> one wr_en_o pulse, wr_addr_o=0, wr_data_o=0x00A00513, done_o=1, num_instr_o=1.
REQ-034 Eight bytes back-to-back, last_i on 8th -> two writes at addresses 0 and 4 exactly 4 cycles apart, num_instr_o=2, done_o=1.
REQ-035 Six bytes with last_i on 6th -> one write at address 0, then error_o=1, done_o=0, num_instr_o=1.
REQ-036 MAX_IMEM_ROWS=4, 17 bytes, no last_i -> four writes (addresses 0,4,8,12), error_o=1 after fourth, byte_ready_o=0, 17th byte not accepted.
REQ-037 rst asserted after 2 bytes of a word, then start_i and 4 bytes with last_i -> single write at address 0 containing only the new bytes.
REQ-038 IMEM_LOADER_BIG_ENDIAN_EN defined, bytes 00,A0,05,13 with last_i -> wr_data_o=0x00A00513.
